quad_enc_gen: RTL
=================

QUAD_ENC_GEN -- requirements
Module: quad_enc_gen

Interface
REQ-001 Parameter COUNT_W, default 32: width of the signed position counter.
REQ-002 Parameter DIV_W, default 16: width of the edge-spacing divider.
REQ-003 Parameter CPR, default 4000: edges per revolution; used only with the index feature.
REQ-004 CLK  in  1  single system clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  generator enable; low aborts any move.
REQ-007 cmd_valid  in  1  move command offered.
REQ-008 cmd_ready  out  1  generator can accept a command.
REQ-009 cmd_steps  in  16  signed edge count; sign selects direction.
REQ-010 edge_period  in  DIV_W  clock cycles between successive edges, sampled at acceptance.
REQ-011 ENC_A, ENC_B  out  1 each  quadrature outputs, registered.
REQ-012 busy  out  1  move in progress.
REQ-013 done  out  1  one-cycle pulse at normal move completion.
REQ-014 position  out  COUNT_W  signed running edge count.

Function
REQ-015 States: IDLE, WAIT, EDGE; cmd_ready = en AND state IDLE.
REQ-016 Accept on cmd_valid AND cmd_ready; latch |cmd_steps| in 17 bits (-32768 gives 32768), direction, and max(edge_period,1).
REQ-017 Accept with cmd_steps = 0: no edges; done pulses the next cycle; remain IDLE.
REQ-018 Accept with nonzero cmd_steps: enter WAIT; busy = 1 from the next cycle.
REQ-019 WAIT counts period cycles; first edge appears on ENC_A/ENC_B exactly period cycles after the acceptance edge.
REQ-020 EDGE lasts one cycle: advance phase, decrement remaining, update position; return to WAIT if remaining > 0, else IDLE with done = 1 that cycle.
REQ-021 Forward (cmd_steps > 0) phase sequence (A,B): 00,10,11,01,00 (A leads); reverse walks it backwards; exactly one output toggles per edge.
REQ-022 Position: +1 per forward edge, -1 per reverse edge, wraps modulo 2^COUNT_W; never changes in IDLE.
REQ-023 en low in any state: next cycle state IDLE, busy 0; remaining steps discarded; no done pulse; ENC_A/ENC_B and position hold.
REQ-024 cmd_valid while busy is ignored (cmd_ready 0); no queuing.
REQ-025 Consecutive commands: phase continues from the last state, never reset between moves.

Reset
REQ-026 On reset: state IDLE, ENC_A = ENC_B = 0, position 0, busy 0, done 0, divider and remaining 0.
REQ-027 Reset mid-move aborts immediately with the above values; no done pulse.

Configuration
REQ-028 With QUAD_ENC_GEN_INDEX_EN defined: extra output ENC_I (1 bit); internal index counter 0..CPR-1 steps with each edge and wraps both directions; ENC_I = 1 when the counter is 0; reset value 0, so ENC_I = 1.
REQ-029 Without QUAD_ENC_GEN_INDEX_EN: no ENC_I port, no index counter; all other behaviour identical.

Structure
REQ-030 State encoding and the forward Gray phase table go in the shared constants file.
REQ-031 One natural sub-module: quad_phase_step (2-bit phase in, direction, advance -> next phase); the divider and FSM stay in quad_enc_gen.

Verification
REQ-032 Reset, then cmd_steps = 8, edge_period = 4 -> 8 edges 4 cycles apart; AB 00,10,11,01,00,10,11,01,00; position 8; one done pulse.
REQ-033 cmd_steps = -3, edge_period = 2 from AB 00 -> AB 01,11,10; position -3; done once.
REQ-034 cmd_steps = 5, edge_period = 10, drop en after 2 edges -> AB holds at 11, position 2, busy 0, no done; next command resumes from 11.
REQ-035 cmd_steps = 0 -> no output change, done pulses one cycle after acceptance; cmd_steps = 1, edge_period = 0 -> edge one cycle after acceptance.
REQ-036 cmd_valid held high during a move -> ignored; cmd_ready returns high only the cycle after done.
REQ-037 With QUAD_ENC_GEN_INDEX_EN and CPR = 4: cmd_steps = 9 -> ENC_I high after reset and after edges 4 and 8 only; reverse 1 step from reset -> ENC_I low, counter 3.

Source files
------------

// File: rtl/quad_enc_gen_pkg.sv
// Shared constants for the quadrature edge generator: FSM state encoding and the
// forward Gray phase table, plus a lookup helper from phase to table position.
package quad_enc_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EDGE = 2'd2
    } state_t;

    // Forward (A leads) phase sequence of {A,B}, entry i at bits [2*i +: 2]: 00,10,11,01
    localparam logic [7:0] FWD_SEQ = {2'b01, 2'b11, 2'b10, 2'b00};

    function automatic logic [1:0] seq_index(input logic [1:0] ab);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (FWD_SEQ[2*i +: 2] == ab) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/quad_enc_gen_phase_step.sv
// Combinational quadrature phase stepper: one Gray-table step forward or back,
// so exactly one of A/B toggles per advance.
module quad_phase_step
    import quad_enc_gen_pkg::*;
(
    input  logic [1:0] i_phase,
    input  logic       i_dir,
    input  logic       i_advance,
    output logic [1:0] o_phase
);

    logic [1:0] w_idx;
    logic [1:0] w_next_idx;

    always_comb begin
        w_idx      = seq_index(i_phase);
        w_next_idx = i_dir ? (w_idx + 2'd1) : (w_idx - 2'd1);
        o_phase    = i_advance ? FWD_SEQ[{w_next_idx, 1'b0} +: 2] : i_phase;
    end

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature encoder signal generator: plays out signed edge-count moves on ENC_A/ENC_B
// at a programmable edge spacing. Define QUAD_ENC_GEN_INDEX_EN to add the ENC_I index output.
module quad_enc_gen
    import quad_enc_gen_pkg::*;
#(
    parameter int COUNT_W = 32,
    parameter int DIV_W   = 16,
    parameter int CPR     = 4000
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               en,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [15:0]        cmd_steps,
    input  logic [DIV_W-1:0]   edge_period,
    output logic               ENC_A,
    output logic               ENC_B,
`ifdef QUAD_ENC_GEN_INDEX_EN
    output logic               ENC_I,
`endif
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] position
);

    state_t             r_state;
    logic [16:0]        r_remaining;
    logic               r_dir;
    logic [DIV_W-1:0]   r_period;
    logic [DIV_W-1:0]   r_div;
    logic [1:0]         r_phase;
    logic [COUNT_W-1:0] r_position;
    logic               r_busy;
    logic               r_done;

    logic [16:0]        w_abs;
    logic [DIV_W-1:0]   w_period;
    logic               w_fire;
    logic [1:0]         w_next_phase;

    // Magnitude needs 17 bits so that -32768 becomes 32768
    assign w_abs    = cmd_steps[15] ? (17'd0 - {1'b1, cmd_steps}) : {1'b0, cmd_steps};
    assign w_period = (edge_period == '0) ? DIV_W'(1) : edge_period;
    assign w_fire   = (r_state != ST_IDLE) && (r_div == DIV_W'(1)) && (r_remaining != 17'd0);

    quad_phase_step u_phase_step (
        .i_phase   (r_phase),
        .i_dir     (r_dir),
        .i_advance (w_fire),
        .o_phase   (w_next_phase)
    );

`ifdef QUAD_ENC_GEN_INDEX_EN
    localparam int IDX_W = (CPR > 1) ? $clog2(CPR) : 1;
    logic [IDX_W-1:0] r_idx;
    assign ENC_I = (r_idx == '0);
`endif

    // NOTE: every register below is assigned with <= so all of them update together
    // from the same pre-edge values; a blocking = here would leak new values mid-block.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_dir       <= 1'b1;
            r_period    <= '0;
            r_div       <= '0;
            r_phase     <= 2'b00;
            r_position  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef QUAD_ENC_GEN_INDEX_EN
            r_idx       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (!en) begin
                // Abort: drop the move but keep phase and position where they are
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_remaining <= '0;
                r_div       <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cmd_valid) begin
                            r_dir    <= ~cmd_steps[15];
                            r_period <= w_period;
                            if (w_abs == 17'd0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_remaining <= w_abs;
                                r_div       <= w_period;
                                r_state     <= ST_WAIT;
                                r_busy      <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT, ST_EDGE: begin
                        if (w_fire) begin
                            r_state     <= ST_EDGE;
                            r_div       <= r_period;
                            r_remaining <= r_remaining - 17'd1;
                            r_phase     <= w_next_phase;
                            r_position  <= r_dir ? (r_position + COUNT_W'(1))
                                                 : (r_position - COUNT_W'(1));
                            if (r_remaining == 17'd1) r_done <= 1'b1;
`ifdef QUAD_ENC_GEN_INDEX_EN
                            if (r_dir)
                                r_idx <= (r_idx == IDX_W'(CPR - 1)) ? '0 : r_idx + IDX_W'(1);
                            else
                                r_idx <= (r_idx == '0) ? IDX_W'(CPR - 1) : r_idx - IDX_W'(1);
`endif
                        end else if (r_state == ST_EDGE && r_remaining == 17'd0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT;
                            r_div   <= r_div - DIV_W'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign cmd_ready = en && (r_state == ST_IDLE);
    assign ENC_A     = r_phase[1];
    assign ENC_B     = r_phase[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign position  = r_position;

endmodule
